// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: reset/bubble constants and the prefetch entry payload.
//   NOP           : bubble instruction (sll $0,$0,0)
//   RESET_PC      : first word address fetched after reset
//   fetch_entry_t : {instr, pc1} pair carried from fetch to IF/ID
package pipeline_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP      = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc1;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO holding fetched {instr, pc1} entries.
//   clk, rst_n : clock, async active-low reset
//   push_i     : write wdata_i (ignored when full)
//   pop_i      : advance head (ignored when empty)
//   flush_i    : empty the queue; dominates push and pop
//   rdata_o    : current head entry
//   count_o    : occupancy, full_o / empty_o status
module fetch_queue
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  fetch_entry_t             wdata_i,
  output fetch_entry_t             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;

  // Pointer/occupancy next state; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read when counted as valid
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch front end: program counter, instruction-memory req/ack port,
// prefetch queue and the IF/ID register feeding decode.
//   CLK, RSTn          : clock, async active-low reset
//   Stall              : hold IF/ID, no pop (fetch continues until full)
//   PCsrc, inMUX       : redirect to inMUX when not stalled; flushes the queue
//   IMemReq/IMemAddr   : read request and word address (FPC)
//   IMemAck/IMemData   : memory accept and same-cycle instruction word
//   Instruction1, PC1  : IF/ID instruction and its address + 1
//   QueueCount         : prefetch queue occupancy
module instruction_fetch_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = pipeline_pkg::RESET_PC,
  parameter logic [31:0] NOP      = pipeline_pkg::NOP
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   Stall,
  input  logic                   PCsrc,
  input  logic [31:0]            inMUX,
  output logic                   IMemReq,
  output logic [31:0]            IMemAddr,
  input  logic                   IMemAck,
  input  logic [31:0]            IMemData,
  output logic [31:0]            Instruction1,
  output logic [31:0]            PC1,
  output logic [$clog2(DEPTH):0] QueueCount
);

  logic [31:0]  fpc_q,   fpc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc1_q,   pc1_d;
  logic         q_push, q_pop, q_flush;
  logic         q_full, q_empty;
  logic         ack_fire;
  fetch_entry_t q_head, q_wdata;

  // Request depends only on registered occupancy, never on Stall/PCsrc
  assign IMemReq      = ~q_full;
  assign IMemAddr     = fpc_q;
  assign ack_fire     = IMemReq & IMemAck;
  assign Instruction1 = instr_q;
  assign PC1          = pc1_q;

  assign q_wdata = '{instr: IMemData, pc1: fpc_q + 32'd1};

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (CLK),
    .rst_n   (RSTn),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .flush_i (q_flush),
    .wdata_i (q_wdata),
    .rdata_o (q_head),
    .count_o (QueueCount),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // Stall > redirect > normal advance; a redirect discards any word acked this cycle
  always_comb begin
    fpc_d   = fpc_q;
    instr_d = instr_q;
    pc1_d   = pc1_q;
    q_push  = 1'b0;
    q_pop   = 1'b0;
    q_flush = 1'b0;
    if (Stall) begin
      q_push = ack_fire;
      if (ack_fire) fpc_d = fpc_q + 32'd1;
    end else if (PCsrc) begin
      q_flush = 1'b1;
      fpc_d   = inMUX;
      instr_d = NOP;
    end else begin
      q_push = ack_fire;
      if (ack_fire) fpc_d = fpc_q + 32'd1;
      if (!q_empty) begin
        q_pop   = 1'b1;
        instr_d = q_head.instr;
        pc1_d   = q_head.pc1;
      end else begin
        instr_d = NOP;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      fpc_q   <= RESET_PC;
      instr_q <= NOP;
      pc1_q   <= 32'd0;
    end else begin
      fpc_q   <= fpc_d;
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
    end
  end

endmodule
